// File: rtl/weight_memory_bank.sv
// ----------------------------------------------------------------------------
// weight_memory_bank: per-neuron weight banks with a serial load stream and a
// parallel read sweep. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module weight_memory_bank #(
  parameter int numNeurons   = 4,
  parameter int numWeights   = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            w_valid,
  input  logic [dataWidth-1:0]            w_data,
  output logic                            w_ready,
  output logic                            load_done,
  input  logic                            reload,
  input  logic                            start,
  output logic [numNeurons*dataWidth-1:0] wout,
  output logic                            wout_valid,
  output logic                            wout_last,
  output logic                            busy
);

  localparam int BANK_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam int DEPTH  = 1 << addressWidth;

  localparam logic [BANK_W-1:0]       LAST_BANK = BANK_W'(numNeurons - 1);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeights - 1);
  localparam logic [addressWidth-1:0] ADDR_ONE  = addressWidth'(1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } state_t;

  state_t                  state;
  logic [BANK_W-1:0]       wbank;
  logic [addressWidth-1:0] waddr;
  logic [addressWidth-1:0] raddr;
  logic                    reload_pending;

  logic accept;
  logic rd_en;

  assign w_ready   = (state == LOAD);
  assign load_done = (state == IDLE) || (state == READ);
  assign busy      = (state == READ);
  assign accept    = w_valid && (state == LOAD);
  assign rd_en     = (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      wbank          <= '0;
      waddr          <= '0;
      raddr          <= '0;
      reload_pending <= 1'b0;
      wout_valid     <= 1'b0;
      wout_last      <= 1'b0;
    end else begin
      wout_valid <= rd_en;
      wout_last  <= rd_en && (raddr == LAST_ADDR);
      case (state)
        LOAD: begin
          if (reload) begin
            wbank <= '0;
            waddr <= '0;
          end else if (accept) begin
            if (waddr == LAST_ADDR) begin
              waddr <= '0;
              if (wbank == LAST_BANK) begin
                wbank <= '0;
                state <= IDLE;
              end else begin
                wbank <= wbank + BANK_W'(1);
              end
            end else begin
              waddr <= waddr + ADDR_ONE;
            end
          end
        end
        IDLE: begin
          // reload wins over a coincident start
          if (reload) begin
            wbank <= '0;
            waddr <= '0;
            state <= LOAD;
          end else if (start) begin
            raddr <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (raddr == LAST_ADDR) begin
            raddr          <= '0;
            reload_pending <= 1'b0;
            if (reload_pending || reload) begin
              wbank <= '0;
              waddr <= '0;
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            raddr <= raddr + ADDR_ONE;
            if (reload) reload_pending <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  generate
    for (genvar n = 0; n < numNeurons; n++) begin : g_bank
      logic [dataWidth-1:0] mem [0:DEPTH-1];
      logic [dataWidth-1:0] q;

      always_ff @(posedge clk) begin
        if (accept && (wbank == BANK_W'(n))) mem[waddr] <= w_data;
      end

      // registered read port; the reset only clears the output register
      always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (rd_en) q <= mem[raddr];
      end

      assign wout[n*dataWidth +: dataWidth] = q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_weight_memory_bank.sv
// ----------------------------------------------------------------------------
// tb_weight_memory_bank: directed self-checking bench, 2 banks x 4 weights.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_weight_memory_bank;

  localparam int NN = 2;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_valid;
  logic [DW-1:0]     w_data;
  logic              w_ready;
  logic              load_done;
  logic              reload;
  logic              start;
  logic [NN*DW-1:0]  wout;
  logic              wout_valid;
  logic              wout_last;
  logic              busy;

  int checks = 0;
  int errors = 0;

  weight_memory_bank #(
    .numNeurons(NN), .numWeights(NW), .addressWidth(AW), .dataWidth(DW)
  ) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .load_done(load_done), .reload(reload), .start(start),
    .wout(wout), .wout_valid(wout_valid), .wout_last(wout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; w_valid = 1'b0; w_data = '0; reload = 1'b0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (w_ready !== 1'b1)    begin errors++; $display("FAIL reset_w_ready got %b exp 1", w_ready); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL reset_load_done got %b exp 0", load_done); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL reset_wout_valid got %b exp 0", wout_valid); end
    checks++; if (wout_last !== 1'b0)  begin errors++; $display("FAIL reset_wout_last got %b exp 0", wout_last); end
    checks++; if (wout !== 32'h0)      begin errors++; $display("FAIL reset_wout got %h exp 00000000", wout); end
  endtask

  // loads 8 words base..base+7; gap inserts an idle cycle after each word
  task automatic load_words(input logic [15:0] base, input bit gap, input bit start_first, input string tag);
    for (int i = 0; i < NN*NW; i++) begin
      checks++;
      if (w_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_word%0d got %b exp 1", tag, i, w_ready); end
      w_valid = 1'b1;
      w_data  = base + 16'(i);
      start   = start_first && (i == 0);
      tick();
      start   = 1'b0;
      if (gap) begin
        w_valid = 1'b0;
        w_data  = 16'hDEAD;
        tick();
      end
    end
    w_valid = 1'b0;
    checks++; if (w_ready !== 1'b0)   begin errors++; $display("FAIL %s_ready_after got %b exp 0", tag, w_ready); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL %s_load_done got %b exp 1", tag, load_done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL %s_busy_idle got %b exp 0", tag, busy); end
  endtask

  // one sweep; reload_at/start_at pulse the input after checking that beat (-1 = never)
  task automatic do_sweep(input logic [15:0] base, input int reload_at, input int start_at, input string tag);
    logic [31:0] exp_w;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL %s_busy got %b exp 1", tag, busy); end
    checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL %s_pre_valid got %b exp 0", tag, wout_valid); end
    for (int k = 0; k < NW; k++) begin
      tick();
      reload = 1'b0;
      start  = 1'b0;
      exp_w  = {16'(base + 16'd4 + 16'(k)), 16'(base + 16'(k))};
      checks++; if (wout_valid !== 1'b1) begin errors++; $display("FAIL %s_valid_beat%0d got %b exp 1", tag, k, wout_valid); end
      checks++; if (wout !== exp_w)      begin errors++; $display("FAIL %s_wout_beat%0d got %h exp %h", tag, k, wout, exp_w); end
      checks++; if (wout_last !== (k == NW-1)) begin errors++; $display("FAIL %s_last_beat%0d got %b exp %b", tag, k, wout_last, (k == NW-1)); end
      if (k == reload_at) reload = 1'b1;
      if (k == start_at)  start  = 1'b1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b exp 0", tag, busy); end
    checks++; if (w_ready !== (reload_at >= 0)) begin errors++; $display("FAIL %s_ready_end got %b exp %b", tag, w_ready, (reload_at >= 0)); end
    tick();
    checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL %s_post_valid got %b exp 0", tag, wout_valid); end
    checks++; if (wout_last !== 1'b0)  begin errors++; $display("FAIL %s_post_last got %b exp 0", tag, wout_last); end
    checks++; if (wout !== exp_w)      begin errors++; $display("FAIL %s_hold got %h exp %h", tag, wout, exp_w); end
  endtask

  task automatic test_back_to_back();
    load_words(16'h0001, 1'b0, 1'b1, "b2b");
    do_sweep(16'h0001, -1, -1, "b2b_sweep");
  endtask

  task automatic test_start_in_read();
    do_sweep(16'h0001, -1, 1, "start_read");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL start_read_extra%0d got %b exp 0", i, wout_valid); end
    end
  endtask

  task automatic test_gapped_load();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL idle_reload_ready got %b exp 1", w_ready); end
    load_words(16'h0001, 1'b1, 1'b0, "gap");
    do_sweep(16'h0001, -1, -1, "gap_sweep");
  endtask

  task automatic test_reload_mid_sweep();
    do_sweep(16'h0001, 1, -1, "reload_mid");
    load_words(16'h0011, 1'b0, 1'b0, "reload2");
    do_sweep(16'h0011, -1, -1, "reload2_sweep");
  endtask

  task automatic test_start_reload_same();
    start = 1'b1; reload = 1'b1;
    tick();
    start = 1'b0; reload = 1'b0;
    checks++; if (w_ready !== 1'b1)   begin errors++; $display("FAIL coincide_ready got %b exp 1", w_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL coincide_busy got %b exp 0", busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL coincide_load_done got %b exp 0", load_done); end
    tick();
    checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL coincide_valid got %b exp 0", wout_valid); end
  endtask

  task automatic test_rst_mid_sweep();
    load_words(16'h0021, 1'b0, 1'b0, "rst_load");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (wout !== 32'h0026_0022) begin errors++; $display("FAIL rst_mid_beat1 got %h exp 00260022", wout); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", wout_valid); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL rst_mid_load_done got %b exp 0", load_done); end
    checks++; if (w_ready !== 1'b1)    begin errors++; $display("FAIL rst_mid_ready got %b exp 1", w_ready); end
    checks++; if (wout !== 32'h0)      begin errors++; $display("FAIL rst_mid_wout got %h exp 00000000", wout); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_nostart%0d got %b exp 0", i, wout_valid); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_back_to_back();
    test_start_in_read();
    test_gapped_load();
    test_reload_mid_sweep();
    test_start_reload_same();
    test_rst_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
